// File: rtl/keypad_display_top.sv
// keypad_display_top
//   4x4 matrix keypad scanner with debounce, a 4-digit multiplexed
//   7-segment display (common anode) and four debug LEDs.
//
//   clk        system clock (27 MHz on the board)
//   rst        asynchronous active-high reset
//   filas_raw  keypad rows, active-high, asynchronous to clk
//   columnas   one-hot active-high column drive
//   d          segments {g,f,e,d,c,b,a}, active-low
//   a          digit enables, active-low, a[0] = rightmost digit
//   led        last accepted key code
module keypad_display_top #(
  parameter int CLK_HZ        = 27_000_000,
  parameter int SCAN_TICKS    = 27_000,
  parameter int DEB_TICKS     = 270_000,
  parameter int REFRESH_TICKS = 27_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas_raw,
  output logic [3:0] columnas,
  output logic [6:0] d,
  output logic [3:0] a,
  output logic [3:0] led
);

  // CLK_HZ only documents the tick parameters; nothing is derived from it.
  if (CLK_HZ > 0) begin : g_clk_doc
  end

  localparam int SW = (SCAN_TICKS    > 1) ? $clog2(SCAN_TICKS)    : 1;
  localparam int DW = (DEB_TICKS     > 1) ? $clog2(DEB_TICKS)     : 1;
  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_TICKS - 1);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  // ---------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------
  logic [3:0] rows_meta, rows;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta <= '0;
      rows      <= '0;
    end else begin
      rows_meta <= filas_raw;
      rows      <= rows_meta;
    end
  end

  // ---------------------------------------------------------------
  // Key decode from the captured rows and the frozen column
  // ---------------------------------------------------------------
  logic [3:0] rows_cap;
  logic [1:0] row_idx, col_idx;
  logic [3:0] code_now;

  // Lowest-index row wins when several are active.
  always_comb begin
    row_idx = 2'd0;
    if      (rows_cap[0]) row_idx = 2'd0;
    else if (rows_cap[1]) row_idx = 2'd1;
    else if (rows_cap[2]) row_idx = 2'd2;
    else if (rows_cap[3]) row_idx = 2'd3;
  end

  always_comb begin
    col_idx = 2'd0;
    if      (columnas[0]) col_idx = 2'd0;
    else if (columnas[1]) col_idx = 2'd1;
    else if (columnas[2]) col_idx = 2'd2;
    else if (columnas[3]) col_idx = 2'd3;
  end

  always_comb begin
    code_now = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: code_now = 4'h1;
      4'b00_01: code_now = 4'h2;
      4'b00_10: code_now = 4'h3;
      4'b00_11: code_now = 4'hA;
      4'b01_00: code_now = 4'h4;
      4'b01_01: code_now = 4'h5;
      4'b01_10: code_now = 4'h6;
      4'b01_11: code_now = 4'hB;
      4'b10_00: code_now = 4'h7;
      4'b10_01: code_now = 4'h8;
      4'b10_10: code_now = 4'h9;
      4'b10_11: code_now = 4'hC;
      4'b11_00: code_now = 4'hE;
      4'b11_01: code_now = 4'h0;
      4'b11_10: code_now = 4'hF;
      4'b11_11: code_now = 4'hD;
      default:  code_now = 4'h0;
    endcase
  end

  // ---------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------
  logic [1:0]    state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    code_q;
  logic          key_valid;

  wire [3:0] col_next = {columnas[2:0], columnas[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SCAN;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      rows_cap  <= '0;
      columnas  <= 4'b0001;
      code_q    <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        S_SCAN: begin
          // A live row takes priority over the dwell timeout so the
          // press is attributed to the column currently driven.
          if (rows != 4'b0000) begin
            state    <= S_DEB;
            rows_cap <= rows;
            deb_cnt  <= '0;
            scan_cnt <= '0;
          end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            columnas <= col_next;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        S_DEB: begin
          // rows_cap is nonzero, so a drop to 0000 is also a change.
          if (rows != rows_cap) begin
            state    <= S_SCAN;
            scan_cnt <= '0;
          end else if (deb_cnt == DEB_MAX) begin
            state     <= S_HELD;
            key_valid <= 1'b1;
            code_q    <= code_now;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (rows == 4'b0000) begin
            state   <= S_REL;
            deb_cnt <= '0;
          end
        end
        default: begin // S_REL
          if (rows != 4'b0000) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_MAX) begin
            state    <= S_SCAN;
            scan_cnt <= '0;
            columnas <= col_next;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Display buffer and LEDs, updated the cycle after key_valid
  // ---------------------------------------------------------------
  logic [3:0][3:0] disp_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_buf <= '0;
      led      <= '0;
    end else if (key_valid) begin
      disp_buf <= {disp_buf[2:0], code_q};
      led      <= code_q;
    end
  end

  // ---------------------------------------------------------------
  // Digit multiplexer
  // ---------------------------------------------------------------
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_sel <= '0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt <= '0;
      dig_sel <= dig_sel + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  logic [3:0] dig_code;

  assign a        = ~(4'b0001 << dig_sel);
  assign dig_code = disp_buf[dig_sel];

  always_comb begin
    d = 7'b1000000;
    case (dig_code)
      4'h0: d = 7'b1000000;
      4'h1: d = 7'b1111001;
      4'h2: d = 7'b0100100;
      4'h3: d = 7'b0110000;
      4'h4: d = 7'b0011001;
      4'h5: d = 7'b0010010;
      4'h6: d = 7'b0000010;
      4'h7: d = 7'b1111000;
      4'h8: d = 7'b0000000;
      4'h9: d = 7'b0010000;
      4'hA: d = 7'b0001000;
      4'hB: d = 7'b0000011;
      4'hC: d = 7'b1000110;
      4'hD: d = 7'b0100001;
      4'hE: d = 7'b0000110;
      4'hF: d = 7'b0001110;
      default: d = 7'b1000000;
    endcase
  end

endmodule

// File: tb/tb_keypad_display_top.sv
// tb_keypad_display_top
//   Keypad matrix model drives the rows from the DUT column outputs.
//   Each press that should be accepted pushes its code into a queue; a
//   monitor pops an entry on every key_valid and compares led.
module tb_keypad_display_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] filas_raw;
  logic [3:0] columnas;
  logic [6:0] d;
  logic [3:0] a;
  logic [3:0] led;

  keypad_display_top #(
    .CLK_HZ(27_000_000), .SCAN_TICKS(100), .DEB_TICKS(200), .REFRESH_TICKS(50)
  ) dut (
    .clk(clk), .rst(rst), .filas_raw(filas_raw),
    .columnas(columnas), .d(d), .a(a), .led(led)
  );

  always #5 clk = ~clk;

  // pressed[row] = bitmask of columns whose key in that row is down
  logic [3:0] pressed [4];

  always_comb begin
    filas_raw = '0;
    for (int r = 0; r < 4; r++) filas_raw[r] = |(pressed[r] & columnas);
  end

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: key_valid is sampled on the falling edge; led is checked
  // one cycle later, when it is due to carry the new code.
  initial begin
    forever begin
      @(negedge clk);
      if (dut.key_valid === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("unexpected_key", {28'd0, led}, 32'hFFFF_FFFF);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("led_on_key", {28'd0, led}, {28'd0, e});
        end
      end
    end
  end

  task automatic check_digit(input int idx, input logic [3:0] code);
    logic [3:0] pat;
    int n;
    pat = ~(4'b0001 << idx);
    n = 0;
    while (a !== pat && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("digit%0d_sel", idx), {28'd0, a}, {28'd0, pat});
    check($sformatf("digit%0d_glyph", idx), {25'd0, d}, {25'd0, glyph[code]});
  endtask

  task automatic press(input int r, input int c, input int hold, input bit accept,
                       input logic [3:0] code);
    if (accept) exp_q.push_back(code);
    pressed[r][c] = 1'b1;
    repeat (hold) @(negedge clk);
    for (int i = 0; i < 4; i++) pressed[i] = '0;
    repeat (400) @(negedge clk);
  endtask

  // Returns the number of cycles until columnas differs from its
  // value on entry, capped at lim.
  task automatic wait_col_change(input int lim, output int n);
    logic [3:0] prev;
    prev = columnas;
    n = 0;
    while (columnas === prev && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0] col_exp;
    for (int i = 0; i < 4; i++) pressed[i] = '0;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_columnas", {28'd0, columnas}, 32'b0001);
    check("rst_a", {28'd0, a}, 32'b1110);
    check("rst_d", {25'd0, d}, 32'b1000000);
    check("rst_led", {28'd0, led}, 32'd0);
    rst = 1'b0;

    // Column rotation every 100 cycles
    col_exp = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      col_exp = {col_exp[2:0], col_exp[3]};
      wait_col_change(200, n);
      check($sformatf("step%0d_cycles", s), n, 100);
      check($sformatf("step%0d_col", s), {28'd0, columnas}, {28'd0, col_exp});
    end

    // Single key 2 (row 0, column 1), then release timing
    exp_q.push_back(4'h2);
    pressed[0][1] = 1'b1;
    repeat (1000) @(negedge clk);
    check("single_led", {28'd0, led}, 32'h2);
    check("single_col_frozen", {28'd0, columnas}, 32'b0010);
    pressed[0][1] = 1'b0;
    wait_col_change(400, n);
    check("release_resume", (n >= 200 && n <= 210), 1);
    check("release_col", {28'd0, columnas}, 32'b0100);
    check_digit(0, 4'h2);

    // Shift in 1, 4, 7, 0
    press(0, 0, 1000, 1'b1, 4'h1);
    press(1, 0, 1000, 1'b1, 4'h4);
    press(2, 0, 1000, 1'b1, 4'h7);
    press(3, 1, 1000, 1'b1, 4'h0);
    check_digit(3, 4'h1);
    check_digit(2, 4'h4);
    check_digit(1, 4'h7);
    check_digit(0, 4'h0);

    // A shifts the 1 out
    press(0, 3, 1000, 1'b1, 4'hA);
    check("a_led", {28'd0, led}, 32'hA);
    check_digit(3, 4'h4);
    check_digit(2, 4'h7);
    check_digit(1, 4'h0);
    check_digit(0, 4'hA);

    // Bounce: a 150-cycle pulse never survives debounce
    press(1, 2, 150, 1'b0, 4'h0);
    check("bounce_led", {28'd0, led}, 32'hA);
    check_digit(0, 4'hA);
    wait_col_change(150, n);
    check("bounce_scan_runs", (n < 150), 1);

    // Rows 0 and 2 together on column 0: key 1, once, despite long hold
    exp_q.push_back(4'h1);
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    repeat (5000) @(negedge clk);
    for (int i = 0; i < 4; i++) pressed[i] = '0;
    repeat (400) @(negedge clk);
    check("multi_led", {28'd0, led}, 32'h1);
    check("multi_queue_empty", exp_q.size(), 0);
    check_digit(0, 4'h1);
    check_digit(1, 4'hA);

    // Reset during debounce of key 5
    pressed[1][1] = 1'b1;
    n = 0;
    while (dut.state !== 2'd1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reach_debounce", (n < 600), 1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_columnas", {28'd0, columnas}, 32'b0001);
    check("midrst_a", {28'd0, a}, 32'b1110);
    check("midrst_d", {25'd0, d}, 32'b1000000);
    check("midrst_led", {28'd0, led}, 32'd0);
    for (int i = 0; i < 4; i++) pressed[i] = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    check("post_rst_led", {28'd0, led}, 32'd0);
    check("post_rst_queue", exp_q.size(), 0);
    for (int k = 0; k < 4; k++) check_digit(k, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
